// File: rtl/uart_rx_core_if.sv
// Receive-word handshake between uart_rx_core (master) and its consumer (slave).
interface uart_rx_core_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: 5..9 data bits, optional parity, 1/2 stop bits,
// words delivered over a valid/ready handshake with frame/parity/overrun flags.
module uart_rx_core #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV        = 27,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rxsdi,
    output logic             busy,
    uart_rx_core_if.master   rx_if
);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PH_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BC_W  = 4;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t               state, state_nxt;
    logic                 sync_q1, rx_s, rx_prev;
    logic [DIV_W-1:0]     div_cnt;
    logic [PH_W-1:0]      phase;
    logic [BC_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_flag, frm_flag;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, ferr_q, perr_q, ovr_q;

    logic fall_c, tick_c, mid_c, last_data_c, last_stop_c, frm_now_c, accept_c;
    logic shift_c, par_chk_c, stop_chk_c, word_done_c, clr_frame_c;

    // Two-stage synchroniser plus edge-detect history, all idling high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync_q1 <= rxsdi;
            rx_s    <= sync_q1;
            rx_prev <= rx_s;
        end
    end

    assign fall_c      = rx_prev & ~rx_s;
    assign tick_c      = (div_cnt == DIV_W'(DIV - 1));
    assign mid_c       = tick_c && (phase == ((state == START) ? PH_W'(OVERSAMPLE/2 - 1)
                                                               : PH_W'(OVERSAMPLE - 1)));
    assign last_data_c = (bit_cnt == BC_W'(DATA_BITS - 1));
    assign last_stop_c = (bit_cnt == BC_W'(STOP_BITS - 1));
    assign frm_now_c   = frm_flag | ~rx_s;
    assign accept_c    = valid_q & rx_if.rx_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (fall_c) state_nxt = START;
            START:  if (mid_c)  state_nxt = rx_s ? IDLE : DATA;
            DATA:   if (mid_c && last_data_c) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY: if (mid_c)  state_nxt = STOP;
            // A low final stop sample means the line is still low: park in BREAK
            STOP:   if (mid_c && last_stop_c) state_nxt = rx_s ? IDLE : BREAK;
            BREAK:  if (rx_s)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shift_c     = 1'b0;
        par_chk_c   = 1'b0;
        stop_chk_c  = 1'b0;
        word_done_c = 1'b0;
        clr_frame_c = 1'b0;
        case (state)
            IDLE:   clr_frame_c = 1'b1;
            DATA:   shift_c     = mid_c;
            PARITY: par_chk_c   = mid_c;
            STOP: begin
                stop_chk_c  = mid_c;
                word_done_c = mid_c && last_stop_c;
            end
            default: ;
        endcase
    end

    // Baud divider and bit-phase counters, parked at zero outside a frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            phase   <= '0;
        end else if (state == IDLE || state == BREAK) begin
            div_cnt <= '0;
            phase   <= '0;
        end else if (tick_c) begin
            div_cnt <= '0;
            if ((state == START && mid_c) || phase == PH_W'(OVERSAMPLE - 1)) phase <= '0;
            else                                                             phase <= phase + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            par_flag <= 1'b0;
            frm_flag <= 1'b0;
        end else if (clr_frame_c) begin
            bit_cnt  <= '0;
            par_flag <= 1'b0;
            frm_flag <= 1'b0;
        end else begin
            if (shift_c) begin
                shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                bit_cnt <= last_data_c ? '0 : bit_cnt + 1'b1;
            end
            if (par_chk_c)            par_flag <= rx_s ^ (^shreg) ^ 1'(PARITY_ODD);
            if (stop_chk_c)           bit_cnt  <= bit_cnt + 1'b1;
            if (stop_chk_c && !rx_s)  frm_flag <= 1'b1;
        end
    end

    // Output holding register: a completed word loads only if the slot is free or draining
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            busy  <= (state_nxt != IDLE);
            if (word_done_c && (!valid_q || accept_c)) begin
                data_q  <= shreg;
                ferr_q  <= frm_now_c;
                perr_q  <= par_flag;
                valid_q <= 1'b1;
            end else begin
                if (word_done_c) ovr_q   <= 1'b1;
                if (accept_c)    valid_q <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data    = data_q;
    assign rx_if.rx_valid   = valid_q;
    assign rx_if.frame_err  = ferr_q;
    assign rx_if.parity_err = perr_q;
    assign rx_if.overrun    = ovr_q;
endmodule
